// File: rtl/rotary_multi_ctl.sv
// rtl/rotary_multi_ctl.sv - multi-channel quadrature encoder controller with Avalon-MM registers
//
// Ports:
//   clk_clk, reset_reset_n  clock, synchronous active-low reset
//   rotary_in               raw encoder pins; channel i uses bit 2i = A, bit 2i+1 = B
//   rotary_cw, rotary_ccw   one-cycle detent pulses, one bit per channel
//   avs_*                   register slave, read data valid the cycle after avs_read
//   irq                     level interrupt, OR of sticky flags enabled in the mask
module rotary_multi_ctl #(
  parameter int NUM_CH     = 2,
  parameter int DEBOUNCE   = 1000,
  parameter int DETENT_DIV = 4,
  parameter int COUNT_W    = 16,
  parameter int SATURATE   = 0
) (
  input  logic                clk_clk,
  input  logic                reset_reset_n,
  input  logic [2*NUM_CH-1:0] rotary_in,
  output logic [NUM_CH-1:0]   rotary_cw,
  output logic [NUM_CH-1:0]   rotary_ccw,
  input  logic [3:0]          avs_address,
  input  logic                avs_read,
  output logic [31:0]         avs_readdata,
  input  logic                avs_write,
  input  logic [31:0]         avs_writedata,
  output logic                irq
);

  localparam int DB_W = $clog2(DEBOUNCE + 1);
  localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE);
  localparam logic signed [3:0] DET = 4'(DETENT_DIV);
  localparam logic [3:0] STAT_ADDR = 4'(NUM_CH);
  localparam logic [3:0] MASK_ADDR = 4'(NUM_CH + 1);
  localparam logic signed [COUNT_W-1:0] POS_MAX = {1'b0, {(COUNT_W-1){1'b1}}};
  localparam logic signed [COUNT_W-1:0] POS_MIN = {1'b1, {(COUNT_W-1){1'b0}}};

  logic [2*NUM_CH-1:0] sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
  logic [2*NUM_CH-1:0] deb_q, deb_d, deb_prev_q, deb_prev_d;
  logic [NUM_CH-1:0]   init_q, init_d;
  logic [DB_W-1:0]     db_cnt_q [NUM_CH];
  logic [DB_W-1:0]     db_cnt_d [NUM_CH];
  logic signed [3:0]   acc_q [NUM_CH];
  logic signed [3:0]   acc_d [NUM_CH];
  logic signed [COUNT_W-1:0] pos_q [NUM_CH];
  logic signed [COUNT_W-1:0] pos_d [NUM_CH];
  logic [NUM_CH-1:0]   cw_q, cw_d, ccw_q, ccw_d;
  logic [NUM_CH-1:0]   cw_st_q, cw_st_d, ccw_st_q, ccw_st_d, err_st_q, err_st_d;
  logic [NUM_CH-1:0]   cw_msk_q, cw_msk_d, ccw_msk_q, ccw_msk_d, err_msk_q, err_msk_d;
  logic                irq_q, irq_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                unused_wdata;

  // Only the low bits of each byte lane and the preset width are meaningful.
  assign unused_wdata = ^avs_writedata;

  // Position of an {A,B} pair in the clockwise Gray sequence 00,01,11,10.
  function automatic logic [1:0] gray_idx(input logic [1:0] ab);
    case (ab)
      2'b00:   gray_idx = 2'd0;
      2'b01:   gray_idx = 2'd1;
      2'b11:   gray_idx = 2'd2;
      default: gray_idx = 2'd3;
    endcase
  endfunction

  always_comb begin
    logic [DB_W-1:0]   stable;
    logic [1:0]        pair_new, ab_new, ab_old, delta;
    logic signed [3:0] step, acc_n;
    logic [NUM_CH-1:0] err_set;
    logic              st_clr;

    sync1_d    = rotary_in;
    sync2_d    = sync1_q;
    prev_d     = sync2_q;
    deb_d      = deb_q;
    deb_prev_d = deb_prev_q;
    init_d     = init_q;
    db_cnt_d   = db_cnt_q;
    acc_d      = acc_q;
    pos_d      = pos_q;
    cw_d       = '0;
    ccw_d      = '0;
    err_set    = '0;
    stable     = '0;
    pair_new   = '0;
    ab_new     = '0;
    ab_old     = '0;
    delta      = '0;
    step       = '0;
    acc_n      = '0;

    for (int ch = 0; ch < NUM_CH; ch++) begin
      // Stable count includes the current cycle, so DEBOUNCE=1 accepts immediately.
      pair_new = sync2_q[2*ch +: 2];
      if (pair_new != prev_q[2*ch +: 2])
        stable = DB_W'(1);
      else if (db_cnt_q[ch] == DB_MAX)
        stable = DB_MAX;
      else
        stable = db_cnt_q[ch] + DB_W'(1);
      db_cnt_d[ch] = stable;

      step   = '0;
      ab_new = {deb_q[2*ch], deb_q[2*ch+1]};
      ab_old = {deb_prev_q[2*ch], deb_prev_q[2*ch+1]};
      delta  = gray_idx(ab_new) - gray_idx(ab_old);

      if (init_q[ch]) begin
        // Until the pins first settle, track them with no decoding so an encoder
        // resting in any position at power-up produces no step.
        deb_d[2*ch +: 2]      = pair_new;
        deb_prev_d[2*ch +: 2] = pair_new;
        if (stable == DB_MAX) init_d[ch] = 1'b0;
      end else begin
        if (stable == DB_MAX && pair_new != deb_q[2*ch +: 2])
          deb_d[2*ch +: 2] = pair_new;
        // Decoding the previous debounced change gives the extra cycle of latency.
        deb_prev_d[2*ch +: 2] = deb_q[2*ch +: 2];
        case (delta)
          2'd1:    step = 4'sd1;
          2'd3:    step = -4'sd1;
          2'd2:    err_set[ch] = 1'b1;
          default: step = '0;
        endcase
      end

      acc_n = acc_q[ch] + step;
      if (step != 4'sd0) begin
        if (acc_n == DET) begin
          cw_d[ch]  = 1'b1;
          acc_d[ch] = '0;
          if (!(SATURATE != 0 && pos_q[ch] == POS_MAX))
            pos_d[ch] = pos_q[ch] + COUNT_W'(1);
        end else if (acc_n == -DET) begin
          ccw_d[ch] = 1'b1;
          acc_d[ch] = '0;
          if (!(SATURATE != 0 && pos_q[ch] == POS_MIN))
            pos_d[ch] = pos_q[ch] - COUNT_W'(1);
        end else begin
          acc_d[ch] = acc_n;
        end
      end

      // A preset overrides the count but the event pulse above still fires.
      if (avs_write && avs_address == 4'(ch)) begin
        pos_d[ch] = avs_writedata[COUNT_W-1:0];
        acc_d[ch] = '0;
      end
    end

    // Write-1-to-clear, with a same-cycle set taking priority.
    st_clr    = avs_write && (avs_address == STAT_ADDR);
    cw_st_d   = cw_st_q;
    ccw_st_d  = ccw_st_q;
    err_st_d  = err_st_q;
    cw_msk_d  = cw_msk_q;
    ccw_msk_d = ccw_msk_q;
    err_msk_d = err_msk_q;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      cw_st_d[ch]  = (cw_st_q[ch]  & ~(st_clr & avs_writedata[ch]))      | cw_d[ch];
      ccw_st_d[ch] = (ccw_st_q[ch] & ~(st_clr & avs_writedata[8 + ch]))  | ccw_d[ch];
      err_st_d[ch] = (err_st_q[ch] & ~(st_clr & avs_writedata[16 + ch])) | err_set[ch];
      if (avs_write && avs_address == MASK_ADDR) begin
        cw_msk_d[ch]  = avs_writedata[ch];
        ccw_msk_d[ch] = avs_writedata[8 + ch];
        err_msk_d[ch] = avs_writedata[16 + ch];
      end
    end

    irq_d = |((cw_st_q & cw_msk_q) | (ccw_st_q & ccw_msk_q) | (err_st_q & err_msk_q));

    rdata_d = '0;
    if (avs_read) begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        if (avs_address == 4'(ch)) rdata_d = 32'(pos_q[ch]);
        if (avs_address == STAT_ADDR) begin
          rdata_d[ch]      = cw_st_q[ch];
          rdata_d[8 + ch]  = ccw_st_q[ch];
          rdata_d[16 + ch] = err_st_q[ch];
        end
        if (avs_address == MASK_ADDR) begin
          rdata_d[ch]      = cw_msk_q[ch];
          rdata_d[8 + ch]  = ccw_msk_q[ch];
          rdata_d[16 + ch] = err_msk_q[ch];
        end
      end
    end
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      prev_q     <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      init_q     <= '1;
      cw_q       <= '0;
      ccw_q      <= '0;
      cw_st_q    <= '0;
      ccw_st_q   <= '0;
      err_st_q   <= '0;
      cw_msk_q   <= '0;
      ccw_msk_q  <= '0;
      err_msk_q  <= '0;
      irq_q      <= 1'b0;
      rdata_q    <= '0;
      for (int ch = 0; ch < NUM_CH; ch++) begin
        db_cnt_q[ch] <= '0;
        acc_q[ch]    <= '0;
        pos_q[ch]    <= '0;
      end
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      prev_q     <= prev_d;
      deb_q      <= deb_d;
      deb_prev_q <= deb_prev_d;
      init_q     <= init_d;
      cw_q       <= cw_d;
      ccw_q      <= ccw_d;
      cw_st_q    <= cw_st_d;
      ccw_st_q   <= ccw_st_d;
      err_st_q   <= err_st_d;
      cw_msk_q   <= cw_msk_d;
      ccw_msk_q  <= ccw_msk_d;
      err_msk_q  <= err_msk_d;
      irq_q      <= irq_d;
      rdata_q    <= rdata_d;
      db_cnt_q   <= db_cnt_d;
      acc_q      <= acc_d;
      pos_q      <= pos_d;
    end
  end

  assign rotary_cw    = cw_q;
  assign rotary_ccw   = ccw_q;
  assign avs_readdata = rdata_q;
  assign irq          = irq_q;

endmodule

// File: tb/tb_rotary_multi_ctl.sv
// tb/tb_rotary_multi_ctl.sv - self-checking bench for rotary_multi_ctl (wrap and saturate instances)
module tb_rotary_multi_ctl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  rin;
  logic [3:0]  addr;
  logic        rd, wr;
  logic [31:0] wdata;
  logic [1:0]  cw_w, ccw_w, cw_s, ccw_s;
  logic [31:0] rdata_w, rdata_s;
  logic        irq_w, irq_s;

  always #5 clk = ~clk;

  rotary_multi_ctl #(.NUM_CH(2), .DEBOUNCE(4), .DETENT_DIV(4), .COUNT_W(8), .SATURATE(0)) dut (
    .clk_clk(clk), .reset_reset_n(rst_n), .rotary_in(rin),
    .rotary_cw(cw_w), .rotary_ccw(ccw_w),
    .avs_address(addr), .avs_read(rd), .avs_readdata(rdata_w),
    .avs_write(wr), .avs_writedata(wdata), .irq(irq_w)
  );

  rotary_multi_ctl #(.NUM_CH(2), .DEBOUNCE(4), .DETENT_DIV(4), .COUNT_W(8), .SATURATE(1)) dut_s (
    .clk_clk(clk), .reset_reset_n(rst_n), .rotary_in(rin),
    .rotary_cw(cw_s), .rotary_ccw(ccw_s),
    .avs_address(addr), .avs_read(rd), .avs_readdata(rdata_s),
    .avs_write(wr), .avs_writedata(wdata), .irq(irq_s)
  );

  int total = 0;
  int bad   = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endfunction

  // Read scoreboard: expectation pushed when the read is issued, popped when data returns.
  typedef struct {
    string       name;
    logic [31:0] exp_w;
    logic [31:0] exp_s;
  } rd_exp_t;
  rd_exp_t sb[$];

  always @(posedge clk) begin
    logic    seen;
    rd_exp_t e;
    seen = rd;
    #3;
    if (seen) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_underflow: read data with no expectation queued");
      end else begin
        e = sb.pop_front();
        check({e.name, "_w"}, rdata_w, e.exp_w);
        check({e.name, "_s"}, rdata_s, e.exp_s);
      end
    end
  end

  int cw_cnt[2], ccw_cnt[2], cw_cnt_s[2];
  initial begin
    for (int c = 0; c < 2; c++) begin
      cw_cnt[c] = 0; ccw_cnt[c] = 0; cw_cnt_s[c] = 0;
    end
  end
  always @(posedge clk) begin
    #3;
    for (int c = 0; c < 2; c++) begin
      cw_cnt[c]   += int'(cw_w[c]);
      ccw_cnt[c]  += int'(ccw_w[c]);
      cw_cnt_s[c] += int'(cw_s[c]);
    end
  end

  typedef struct {
    int          ch;
    logic [1:0]  ab;
    int          cw;
    int          ccw;
    logic [31:0] pos;
    string       name;
  } vec_t;
  vec_t tbl[14];

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_ab(input int ch, input logic [1:0] ab);
    rin[2*ch]   = ab[1];
    rin[2*ch+1] = ab[0];
  endtask

  task automatic rd_reg(input logic [3:0] a, input logic [31:0] ew, input logic [31:0] es, input string nm);
    sb.push_back('{nm, ew, es});
    addr = a;
    rd   = 1'b1;
    @(negedge clk);
    rd   = 1'b0;
  endtask

  task automatic wr_reg(input logic [3:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    wr    = 1'b1;
    @(negedge clk);
    wr    = 1'b0;
  endtask

  // Applies table rows lo..hi (all on one channel); pulse counts are relative to row lo.
  task automatic run_vecs(input int lo, input int hi);
    int b_cw, b_ccw, ch;
    ch = tbl[lo].ch;
    b_cw = cw_cnt[ch];
    b_ccw = ccw_cnt[ch];
    for (int i = lo; i <= hi; i++) begin
      set_ab(ch, tbl[i].ab);
      cyc(10);
      check({tbl[i].name, "_cw"}, 32'(cw_cnt[ch] - b_cw), 32'(tbl[i].cw));
      check({tbl[i].name, "_ccw"}, 32'(ccw_cnt[ch] - b_ccw), 32'(tbl[i].ccw));
      rd_reg(4'(ch), tbl[i].pos, tbl[i].pos, {tbl[i].name, "_pos"});
    end
  endtask

  initial begin
    int b_cw, b_ccw, b_cws, hit;

    tbl[0]  = '{0, 2'b01, 0, 0, 32'h0, "cwa1"};
    tbl[1]  = '{0, 2'b11, 0, 0, 32'h0, "cwa2"};
    tbl[2]  = '{0, 2'b10, 0, 0, 32'h0, "cwa3"};
    tbl[3]  = '{0, 2'b01, 0, 0, 32'h0, "fwd1"};
    tbl[4]  = '{0, 2'b11, 0, 0, 32'h0, "fwd2"};
    tbl[5]  = '{0, 2'b01, 0, 0, 32'h0, "rev1"};
    tbl[6]  = '{0, 2'b00, 0, 0, 32'h0, "rev2"};
    tbl[7]  = '{0, 2'b10, 0, 0, 32'h0, "ccw1"};
    tbl[8]  = '{0, 2'b11, 0, 0, 32'h0, "ccw2"};
    tbl[9]  = '{0, 2'b01, 0, 0, 32'h0, "ccw3"};
    tbl[10] = '{0, 2'b00, 0, 1, 32'hFFFF_FFFF, "ccw4"};
    tbl[11] = '{1, 2'b11, 0, 0, 32'h0, "bccw2"};
    tbl[12] = '{1, 2'b01, 0, 0, 32'h0, "bccw3"};
    tbl[13] = '{1, 2'b00, 0, 1, 32'hFFFF_FFFF, "bccw4"};

    rst_n = 1'b0; rin = '0; addr = '0; rd = 1'b0; wr = 1'b0; wdata = '0;
    cyc(3);
    rst_n = 1'b1;
    cyc(10);

    // Reset state
    check("rst_cw", {30'd0, cw_w | cw_s}, 32'd0);
    check("rst_irq", {30'd0, irq_w, irq_s}, 32'd0);
    rd_reg(4'd0, 32'h0, 32'h0, "rst_pos0");
    rd_reg(4'd1, 32'h0, 32'h0, "rst_pos1");
    rd_reg(4'd2, 32'h0, 32'h0, "rst_stat");
    rd_reg(4'd3, 32'h0, 32'h0, "rst_mask");
    wr_reg(4'd9, 32'hFFFF_FFFF);
    rd_reg(4'd9, 32'h0, 32'h0, "unmapped");
    rd_reg(4'd3, 32'h0, 32'h0, "mask_after_unmapped_wr");

    // Ch0 full clockwise cycle; the last quarter-step is timed exactly
    b_cw = cw_cnt[0];
    run_vecs(0, 2);
    set_ab(0, 2'b00);
    hit = -1;
    for (int k = 1; k <= 7; k++) begin
      cyc(1);
      if (cw_w[0] && hit < 0) hit = k;
    end
    rd_reg(4'd0, 32'h1, 32'h1, "cw_cycle_pos");
    check("cw_latency", 32'(hit), 32'd7);
    cyc(5);
    check("cw_cycle_pulses", 32'(cw_cnt[0] - b_cw), 32'd1);
    rd_reg(4'd2, 32'h1, 32'h1, "cw_cycle_stat");

    // Ch0 reversal and counter-clockwise detent to -1
    wr_reg(4'd0, 32'h0);
    run_vecs(3, 10);
    wr_reg(4'd2, 32'hFFFF_FFFF);
    rd_reg(4'd2, 32'h0, 32'h0, "w1c_all");

    // Ch1 bounce: only the settled value is accepted
    b_cw = cw_cnt[1];
    b_ccw = ccw_cnt[1];
    for (int k = 0; k < 10; k++) begin
      set_ab(1, (k % 2 == 0) ? 2'b10 : 2'b00);
      cyc(2);
    end
    set_ab(1, 2'b10);
    cyc(12);
    check("bounce_cw", 32'(cw_cnt[1] - b_cw), 32'd0);
    check("bounce_ccw", 32'(ccw_cnt[1] - b_ccw), 32'd0);
    rd_reg(4'd1, 32'h0, 32'h0, "bounce_pos");
    rd_reg(4'd2, 32'h0, 32'h0, "bounce_stat");
    // Three more CCW quarter-steps complete the detent only if the bounce gave one
    run_vecs(11, 13);
    rd_reg(4'd2, 32'h200, 32'h200, "bounce_ccw_stat");

    // Invalid transition on ch1 with masked interrupt
    wr_reg(4'd2, 32'hFFFF_FFFF);
    wr_reg(4'd3, 32'h0002_0000);
    set_ab(1, 2'b11);
    cyc(7);
    check("irq_before", {30'd0, irq_w, irq_s}, 32'd0);
    cyc(1);
    check("irq_rise", {30'd0, irq_w, irq_s}, 32'd3);
    rd_reg(4'd2, 32'h0002_0000, 32'h0002_0000, "err_stat");
    rd_reg(4'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "err_pos");
    rd_reg(4'd3, 32'h0002_0000, 32'h0002_0000, "mask_rb");
    wr_reg(4'd2, 32'h0002_0000);
    check("irq_hold", {30'd0, irq_w, irq_s}, 32'd3);
    cyc(1);
    check("irq_clear", {30'd0, irq_w, irq_s}, 32'd0);
    rd_reg(4'd2, 32'h0, 32'h0, "err_cleared");

    // Overflow: wrap on one instance, clamp on the other
    wr_reg(4'd0, 32'h7F);
    b_cw = cw_cnt[0];
    b_cws = cw_cnt_s[0];
    set_ab(0, 2'b01); cyc(10);
    set_ab(0, 2'b11); cyc(10);
    set_ab(0, 2'b10); cyc(10);
    set_ab(0, 2'b00); cyc(10);
    check("ovf_cw_w", 32'(cw_cnt[0] - b_cw), 32'd1);
    check("ovf_cw_s", 32'(cw_cnt_s[0] - b_cws), 32'd1);
    rd_reg(4'd0, 32'hFFFF_FF80, 32'h7F, "ovf_pos");

    // Preset landing on the same edge as a cw event
    set_ab(0, 2'b01); cyc(10);
    set_ab(0, 2'b11); cyc(10);
    set_ab(0, 2'b10); cyc(10);
    set_ab(0, 2'b00); cyc(6);
    wr_reg(4'd0, 32'h42);
    check("coinc_pulse", {30'd0, cw_w[0], cw_s[0]}, 32'd3);
    rd_reg(4'd0, 32'h42, 32'h42, "coinc_pos");
    rd_reg(4'd2, 32'h1, 32'h1, "coinc_stat");
    check("coinc_irq", {30'd0, irq_w, irq_s}, 32'd0);

    // Reset in the middle of a debounce window
    set_ab(0, 2'b01);
    cyc(3);
    rst_n = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    b_cw = cw_cnt[0];
    b_ccw = ccw_cnt[0];
    cyc(20);
    check("rstmid_cw", 32'(cw_cnt[0] - b_cw), 32'd0);
    check("rstmid_ccw", 32'(ccw_cnt[0] - b_ccw), 32'd0);
    rd_reg(4'd0, 32'h0, 32'h0, "rstmid_pos0");
    rd_reg(4'd1, 32'h0, 32'h0, "rstmid_pos1");
    rd_reg(4'd2, 32'h0, 32'h0, "rstmid_stat");
    rd_reg(4'd3, 32'h0, 32'h0, "rstmid_mask");
    check("rstmid_irq", {30'd0, irq_w, irq_s}, 32'd0);

    cyc(3);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL sb_leftover: %0d reads never returned, expected 0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
